// File: rtl/rv32_mod_instruction_fetch.sv
// rtl/rv32_mod_instruction_fetch.sv - RV32 fetch unit with a 3-halfword prefetch buffer
// RV32_FETCH_COMPRESSED_EN: halfword granularity with 16-bit instructions; otherwise word-only fetch.
module rv32_mod_instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        mem_err,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   output logic        instr_fault
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_FAULT} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [47:0] r_buf;
   logic [1:0]  r_count;
   logic [31:0] r_fetch_pc;
   logic [31:0] r_instr_pc;
   logic [31:0] r_old_addr;
   logic        r_discard;
   logic        r_fault_done;

   logic        w_ack_ok;
   logic        w_ack_err;
   logic        w_hw0_is16;
   logic        w_complete;
   logic        w_fire;
   logic        w_redir_flt;
   logic [1:0]  w_cons_n;
   logic [1:0]  w_app_n;
   logic [1:0]  w_cnt_c;
   logic [1:0]  w_cnt_nxt;
   logic [31:0] w_app_data;
   logic [47:0] w_shift;
   logic [47:0] w_mask;
   logic [47:0] w_buf_nxt;

   // A response arriving while r_discard is set belongs to a flushed request.
   assign w_ack_ok  = (r_state == S_FETCH) && mem_ack && !mem_err && !r_discard;
   assign w_ack_err = (r_state == S_FETCH) && mem_ack && mem_err && !r_discard;
   assign w_fire    = instr_valid && instr_ready;

   always_comb begin
      w_hw0_is16  = 1'b0;
      w_app_data  = 32'h0;
      w_app_n     = 2'd0;
      w_redir_flt = 1'b0;
`ifdef RV32_FETCH_COMPRESSED_EN
      w_hw0_is16 = (r_buf[1:0] != 2'b11);
      if (w_ack_ok) begin
         w_app_data = r_fetch_pc[1] ? {16'h0, mem_rdata[31:16]} : mem_rdata;
         w_app_n    = r_fetch_pc[1] ? 2'd1 : 2'd2;
      end
`else
      w_redir_flt = redirect_pc[1];
      if (w_ack_ok) begin
         w_app_data = mem_rdata;
         w_app_n    = 2'd2;
      end
`endif
      w_complete = ((r_count >= 2'd1) && w_hw0_is16) || (r_count >= 2'd2);
      w_cons_n   = 2'd0;
      if (w_fire && w_complete) begin
         w_cons_n = w_hw0_is16 ? 2'd1 : 2'd2;
      end
      w_cnt_c   = r_count - w_cons_n;
      w_cnt_nxt = w_cnt_c + w_app_n;
      w_shift   = r_buf >> {w_cons_n, 4'b0000};
      w_mask    = (48'h1 << {w_cnt_c, 4'b0000}) - 48'h1;
      w_buf_nxt = (w_shift & w_mask) | ({16'h0, w_app_data} << {w_cnt_c, 4'b0000});
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (redirect_valid) begin
         w_state_nxt = w_redir_flt ? S_FAULT : S_FETCH;
      end else begin
         case (r_state)
            S_IDLE:  w_state_nxt = S_FETCH;
            S_FETCH: begin
               if (w_ack_err) begin
                  w_state_nxt = S_FAULT;
               end else if (w_ack_ok && (w_cnt_nxt > 2'd1)) begin
                  w_state_nxt = S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_cnt_nxt <= 2'd1) begin
                  w_state_nxt = S_FETCH;
               end
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_comb begin
      mem_req     = r_discard || (r_state == S_FETCH);
      mem_addr    = r_discard ? r_old_addr : (r_fetch_pc & ~32'd3);
      instr_valid = w_complete || ((r_state == S_FAULT) && !r_fault_done);
      instr_fault = (r_state == S_FAULT) && !r_fault_done && !w_complete;
      instruction = w_hw0_is16 ? {16'h0, r_buf[15:0]} : r_buf[31:0];
      instr_pc    = r_instr_pc;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_buf        <= 48'h0;
         r_count      <= 2'd0;
         r_fetch_pc   <= RESET_PC;
         r_instr_pc   <= RESET_PC;
         r_old_addr   <= 32'h0;
         r_discard    <= 1'b0;
         r_fault_done <= 1'b0;
      end else begin
         if (r_discard && mem_ack) begin
            r_discard <= 1'b0;
         end
         if (redirect_valid) begin
            r_count      <= 2'd0;
            r_fetch_pc   <= redirect_pc;
            r_instr_pc   <= redirect_pc;
            r_fault_done <= 1'b0;
            // The bus still owns the old request; keep presenting it until it completes.
            if (!r_discard && (r_state == S_FETCH) && !mem_ack) begin
               r_discard  <= 1'b1;
               r_old_addr <= mem_addr;
            end
         end else begin
            r_count <= w_cnt_nxt;
            r_buf   <= w_buf_nxt;
            if (w_ack_ok) begin
               r_fetch_pc <= (r_fetch_pc & ~32'd3) + 32'd4;
            end
            if (w_cons_n != 2'd0) begin
               r_instr_pc <= r_instr_pc + {29'd0, w_cons_n, 1'b0};
            end
            if (w_fire && !w_complete) begin
               r_fault_done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rv32_mod_instruction_fetch.sv
// tb/tb_rv32_mod_instruction_fetch.sv - scoreboard bench for rv32_mod_instruction_fetch
module tb_rv32_mod_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        mem_err;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic [31:0] instr_pc;
   logic        instr_fault;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fault;
   } exp_t;

   exp_t        sb_q[$];
   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] mem [logic [31:0]];
   int          mem_lat = 0;
   int          lat_cnt = 0;
   logic [31:0] err_addr = 32'hFFFF_FFFF;
   int          held;

   always #5 clk = ~clk;

   rv32_mod_instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .mem_err        (mem_err),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instruction    (instruction),
      .instr_pc       (instr_pc),
      .instr_fault    (instr_fault)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] i, input logic [31:0] pc, input logic f);
      sb_q.push_back({i, pc, f});
   endtask

   task automatic redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      tick();
      redirect_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int k;
      k = 0;
      while (sb_q.size() != 0 && k < budget) begin
         tick();
         k++;
      end
      n_vec++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL %s: %0d entries still pending after %0d cycles, expected 0", name, sb_q.size(), budget);
         sb_q.delete();
      end
      instr_ready = 1'b0;
   endtask

   // Memory responder: answers after mem_lat waiting cycles, zero-wait when mem_lat is 0.
   initial begin : mem_model
      mem_ack   = 1'b0;
      mem_err   = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         mem_err = 1'b0;
         if (!rst_n || !mem_req) begin
            lat_cnt = 0;
         end else if (lat_cnt >= mem_lat) begin
            mem_ack   = 1'b1;
            mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0000_0013;
            mem_err   = (mem_addr == err_addr);
            lat_cnt   = 0;
         end else begin
            lat_cnt++;
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && instr_valid && instr_ready) begin
            if (sb_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_instr: got %h at pc %h fault %b, expected none",
                        instruction, instr_pc, instr_fault);
            end else begin
               e = sb_q.pop_front();
               check("instr_fault", {31'd0, instr_fault}, {31'd0, e.fault});
               check("instr_pc", instr_pc, e.pc);
               if (!e.fault) check("instruction", instruction, e.instr);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
      $fatal(1);
   end

   initial begin : stimulus
      mem[32'h0000_0000] = 32'h0000_0013;
      mem[32'h0000_0004] = 32'h0010_0093;
      mem[32'h0000_0008] = 32'h0020_0113;
      mem[32'h0000_000C] = 32'h0030_0193;
      mem[32'h0000_0010] = 32'h0040_0213;
      mem[32'h0000_0038] = 32'h0050_0313;
      mem[32'h0000_003C] = 32'h0060_0393;
      mem[32'h0000_0100] = 32'h0513_4501;
      mem[32'h0000_0104] = 32'h0000_0000;
      mem[32'h0000_0200] = 32'h0200_0293;
      mem[32'h0000_0300] = 32'h0070_0413;
      mem[32'h0000_0400] = 32'h0001_4501;
      mem[32'h0000_0404] = 32'h0000_0013;

      rst_n          = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      repeat (3) tick();
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_instr_fault", {31'd0, instr_fault}, 32'd0);
      check("rst_instruction", instruction, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);

      // Zero-wait fetch straight out of reset, then a short straight-line run.
      push(32'h0000_0013, 32'h0, 1'b0);
      push(32'h0010_0093, 32'h4, 1'b0);
      push(32'h0020_0113, 32'h8, 1'b0);
      push(32'h0030_0193, 32'hC, 1'b0);
      instr_ready = 1'b1;
      rst_n       = 1'b1;
      check("c0_mem_req", {31'd0, mem_req}, 32'd0);
      tick();
      check("c1_mem_req", {31'd0, mem_req}, 32'd1);
      check("c1_mem_addr", mem_addr, 32'h0);
      tick();
      check("c2_instr_valid", {31'd0, instr_valid}, 32'd1);
      wait_drain("drain_straight", 40);

      // Decoder stall: presented entry holds, fetching stops once the buffer is full.
      tick();
      for (int i = 0; i < 5; i++) begin
         check("stall_mem_req", {31'd0, mem_req}, 32'd0);
         check("stall_valid", {31'd0, instr_valid}, 32'd1);
         check("stall_instruction", instruction, 32'h0040_0213);
         check("stall_pc", instr_pc, 32'h10);
         tick();
      end

      // Redirect over an outstanding request: old address held until ack, data dropped.
      mem_lat = 3;
      redirect(32'h8);
      redirect(32'h200);
      held = 0;
      for (int k = 0; k < 10; k++) begin
         if (mem_addr != 32'h8) break;
         check("held_mem_req", {31'd0, mem_req}, 32'd1);
         held++;
         tick();
      end
      check("held_cycles", held, 32'd3);
      check("after_ack_mem_req", {31'd0, mem_req}, 32'd1);
      check("after_ack_mem_addr", mem_addr, 32'h200);
      push(32'h0200_0293, 32'h200, 1'b0);
      instr_ready = 1'b1;
      wait_drain("drain_redirect", 40);

      // Bus error at 0x40 after two good instructions.
      mem_lat  = 1;
      err_addr = 32'h40;
      push(32'h0050_0313, 32'h38, 1'b0);
      push(32'h0060_0393, 32'h3C, 1'b0);
      push(32'h0, 32'h40, 1'b1);
      redirect(32'h38);
      instr_ready = 1'b1;
      wait_drain("drain_fault", 60);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("post_fault_mem_req", {31'd0, mem_req}, 32'd0);
         check("post_fault_valid", {31'd0, instr_valid}, 32'd0);
      end

`ifdef RV32_FETCH_COMPRESSED_EN
      push(32'h0000_4501, 32'h400, 1'b0);
      push(32'h0000_0001, 32'h402, 1'b0);
      push(32'h0000_0013, 32'h404, 1'b0);
      instr_ready = 1'b1;
      redirect(32'h400);
      wait_drain("drain_compressed", 60);
      push(32'h0000_0513, 32'h102, 1'b0);
      push(32'h0000_0000, 32'h106, 1'b0);
      instr_ready = 1'b1;
      redirect(32'h102);
      wait_drain("drain_misaligned", 60);
`else
      // Word-only build: a halfword-aligned target faults without touching the bus.
      push(32'h0, 32'h302, 1'b1);
      instr_ready = 1'b1;
      redirect(32'h302);
      wait_drain("drain_misaligned_fault", 20);
      for (int i = 0; i < 3; i++) begin
         check("misaligned_mem_req", {31'd0, mem_req}, 32'd0);
         tick();
      end
      push(32'h0070_0413, 32'h300, 1'b0);
      instr_ready = 1'b1;
      redirect(32'h300);
      wait_drain("drain_recover", 40);
`endif

      // Reset while a slow request is outstanding.
      mem_lat = 5;
      redirect(32'h20);
      tick();
      check("pre_reset_mem_req", {31'd0, mem_req}, 32'd1);
      rst_n = 1'b0;
      tick();
      check("mid_reset_mem_req", {31'd0, mem_req}, 32'd0);
      check("mid_reset_mem_addr", mem_addr, 32'h0);
      check("mid_reset_valid", {31'd0, instr_valid}, 32'd0);
      mem_lat = 0;
      push(32'h0000_0013, 32'h0, 1'b0);
      instr_ready = 1'b1;
      rst_n       = 1'b1;
      tick();
      check("rerst_c1_mem_req", {31'd0, mem_req}, 32'd1);
      check("rerst_c1_mem_addr", mem_addr, 32'h0);
      wait_drain("drain_rereset", 20);

      repeat (2) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
